pcie_rst_seq: RTL

//  Parametrised reset / link bring-up sequencer for one PCIe root port plus N-1 endpoints.

---
 rtl/pcie_rst_seq_pkg.sv | 28 ++
 rtl/pcie_rst_seq_sync_2ff.sv | 29 ++
 rtl/pcie_rst_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pcie_rst_seq_pkg.sv
// Shared types and sizing helpers for the PCIe reset / link bring-up sequencer.
package pcie_rst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RELEASE,
        WAIT_LINK,
        UP,
        FAIL
    } state_e;

    // One counter serves hold, release stagger and link-up timeout, so size it for the longest.
    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned stagger_span,
                                              input int unsigned linkup_timeout);
        int unsigned m;
        m = hold_cycles;
        if (stagger_span > m) m = stagger_span;
        if (linkup_timeout > m) m = linkup_timeout;
        return $clog2(m + 1);
    endfunction

    function automatic int unsigned rty_width(input int unsigned max_retry);
        return (max_retry == 0) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/pcie_rst_seq_sync_2ff.sv
// Two-flop synchroniser for one asynchronous level, cleared to 0 by reset.
module pcie_rst_seq_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pcie_rst_seq.sv
// Reset / link bring-up sequencer: hold all devices, release them staggered,
// wait for every link, retry on timeout or link drop, report pass or fail.
module pcie_rst_seq
    import pcie_rst_seq_pkg::*;
#(
    parameter int unsigned NUM_DEV        = 2,
    parameter int unsigned HOLD_CYCLES    = 500,
    parameter int unsigned STAGGER_CYCLES = 16,
    parameter int unsigned LINKUP_TIMEOUT = 65536,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned AUTO_START     = 1
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst,
    input  logic                               start,
    input  logic [NUM_DEV-1:0]                 link_up,
    output logic [NUM_DEV-1:0]                 dev_rst_n,
    output logic                               busy,
    output logic                               all_up,
    output logic                               fail,
    output logic [NUM_DEV-1:0]                 fail_mask,
    output logic [rty_width(MAX_RETRY)-1:0]    retry_cnt
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, NUM_DEV * STAGGER_CYCLES, LINKUP_TIMEOUT);
    localparam int unsigned RTY_W = rty_width(MAX_RETRY);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((NUM_DEV - 1) * STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LINKUP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

    logic [NUM_DEV-1:0] link_s;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [NUM_DEV-1:0] mask_q, mask_d;
    logic [NUM_DEV-1:0] dev_q, dev_d;
    logic               busy_q, busy_d;
    logic               all_up_q, all_up_d;
    logic               fail_q, fail_d;
    logic               auto_q, auto_d;
    logic               link_lost;

    for (genvar g = 0; g < NUM_DEV; g++) begin : g_sync
        pcie_rst_seq_sync_2ff u_sync (
            .clk (sys_clk),
            .rst (sys_rst),
            .d   (link_up[g]),
            .q   (link_s[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        retry_d   = retry_q;
        mask_d    = mask_q;
        dev_d     = dev_q;
        auto_d    = 1'b0;
        link_lost = 1'b0;

        case (state_q)
            IDLE:      if (start || auto_q) state_d = HOLD;
            HOLD:      if (cnt_q == HOLD_LAST) state_d = RELEASE;
            RELEASE:   if (cnt_q == REL_LAST) state_d = WAIT_LINK;
            WAIT_LINK: begin
                if (&link_s) state_d = UP;
                else if (cnt_q == TMO_LAST) link_lost = 1'b1;
            end
            UP:        if (!(&link_s)) link_lost = 1'b1;
            FAIL: begin
                if (start) begin
                    state_d = HOLD;
                    retry_d = '0;
                    mask_d  = '0;
                end
            end
            default:   state_d = IDLE;
        endcase

        // Timeout and link drop share one retry path back through HOLD.
        if (link_lost) begin
            mask_d = ~link_s;
            if (retry_q < RTY_MAX) begin
                retry_d = retry_q + RTY_W'(1);
                state_d = HOLD;
            end else begin
                state_d = FAIL;
            end
        end

        if (state_d != state_q) cnt_d = '0;
        if (state_d == UP && state_q != UP) mask_d = '0;

        // Device i is released when the RELEASE cycle it will see equals i*STAGGER_CYCLES.
        case (state_d)
            IDLE, HOLD: dev_d = '0;
            RELEASE: begin
                for (int unsigned i = 0; i < NUM_DEV; i++) begin
                    if (cnt_d == CNT_W'(i * STAGGER_CYCLES)) dev_d[i] = 1'b1;
                end
            end
            default: dev_d = dev_q;
        endcase

        busy_d   = (state_d == HOLD) || (state_d == RELEASE) || (state_d == WAIT_LINK);
        all_up_d = (state_d == UP);
        fail_d   = (state_d == FAIL);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            retry_q  <= '0;
            mask_q   <= '0;
            dev_q    <= '0;
            busy_q   <= 1'b0;
            all_up_q <= 1'b0;
            fail_q   <= 1'b0;
            auto_q   <= (AUTO_START != 0);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            mask_q   <= mask_d;
            dev_q    <= dev_d;
            busy_q   <= busy_d;
            all_up_q <= all_up_d;
            fail_q   <= fail_d;
            auto_q   <= auto_d;
        end
    end

    assign dev_rst_n = dev_q;
    assign busy      = busy_q;
    assign all_up    = all_up_q;
    assign fail      = fail_q;
    assign fail_mask = mask_q;
    assign retry_cnt = retry_q;

endmodule
